// File: rtl/pipe_hz_pkg.sv
// Shared definitions for the pipeline hazard scoreboard: counter width derivation,
// forwarding encoding and stall-cause labels.
package pipe_hz_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Counter must hold the longest issue latency plus the writeback distance.
  function automatic int cnt_width(input int max_lat, input int wb_dist);
    return (clog2(max_lat + wb_dist + 1) < 1) ? 1 : clog2(max_lat + wb_dist + 1);
  endfunction

  localparam int FWD_REGFILE = 0;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RAW  = 2'd1,
    WAW  = 2'd2
  } stall_cause_e;

endpackage

// File: rtl/pipe_hazard_scoreboard_sb_cell.sv
// One scoreboard entry: a saturating countdown with a priority load and a
// flush-restore path.
module sb_cell #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             restore_i,
  input  logic [CNT_W-1:0] restore_val_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a new load beats a restore, which beats the ageing decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (restore_i) begin
      cnt_d = restore_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Per-register in-flight write scoreboard producing decode stall and forwarding selects.
// Optional stall statistics outputs are enabled by defining SCOREBOARD_STATS_EN.
module pipe_hazard_scoreboard
  import pipe_hz_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int NUM_REGS   = 32,
  parameter  int MAX_LAT    = 7,
  parameter  int WB_DIST    = 2,
  parameter  int ZERO_REG   = 1,
  localparam int CNT_W      = cnt_width(MAX_LAT, WB_DIST)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rs_i,
  input  logic [REG_ADDR_W-1:0] issue_rt_i,
  input  logic                  issue_use_rs_i,
  input  logic                  issue_use_rt_i,
  input  logic                  issue_wr_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [CNT_W-1:0]      issue_lat_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  issue_acc_o,
  output logic [CNT_W-1:0]      fwd_rs_o,
  output logic [CNT_W-1:0]      fwd_rt_o
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stat_raw_o,
  output logic [31:0]           stat_waw_o
`endif
);

  localparam logic [CNT_W-1:0] WB_C   = CNT_W'(WB_DIST);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FWD_RF = CNT_W'(FWD_REGFILE);

  logic [CNT_W-1:0]      cnt_s [NUM_REGS];
  logic [CNT_W-1:0]      rs_cnt_s, rt_cnt_s, rd_cnt_s;
  logic [CNT_W-1:0]      lat_c_s, tgt_s, load_val_s, restore_val_s;
  logic                  raw_s, waw_s, stall_s, acc_s, wr_acc_s, restore_s;
  logic                  lw_valid_q, lw_valid_d;
  logic [REG_ADDR_W-1:0] lw_reg_q, lw_reg_d;
  logic [CNT_W-1:0]      lw_prev_q, lw_prev_d;

  // Operand lookups; a hard-wired r0 always reads as idle.
  always_comb begin
    rs_cnt_s = {CNT_W{1'b0}};
    rt_cnt_s = {CNT_W{1'b0}};
    rd_cnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rs_cnt_s = (issue_rs_i == REG_ADDR_W'(i)) ? cnt_s[i] : rs_cnt_s;
      rt_cnt_s = (issue_rt_i == REG_ADDR_W'(i)) ? cnt_s[i] : rt_cnt_s;
      rd_cnt_s = (issue_rd_i == REG_ADDR_W'(i)) ? cnt_s[i] : rd_cnt_s;
    end
    if (ZERO_REG != 0) begin
      rs_cnt_s = (issue_rs_i == {REG_ADDR_W{1'b0}}) ? {CNT_W{1'b0}} : rs_cnt_s;
      rt_cnt_s = (issue_rt_i == {REG_ADDR_W{1'b0}}) ? {CNT_W{1'b0}} : rt_cnt_s;
      rd_cnt_s = (issue_rd_i == {REG_ADDR_W{1'b0}}) ? {CNT_W{1'b0}} : rd_cnt_s;
    end else begin
      rs_cnt_s = rs_cnt_s;
    end
  end

  // Hazard detection; the stored count already reflects the accept-cycle edge.
  always_comb begin
    if (issue_lat_i == {CNT_W{1'b0}}) begin
      lat_c_s = ONE_C;
    end else if (issue_lat_i > MAX_C) begin
      lat_c_s = MAX_C;
    end else begin
      lat_c_s = issue_lat_i;
    end
    tgt_s      = lat_c_s + WB_C;
    load_val_s = tgt_s - ONE_C;
    raw_s      = (issue_use_rs_i && (rs_cnt_s > WB_C)) || (issue_use_rt_i && (rt_cnt_s > WB_C));
    waw_s      = issue_wr_i && (rd_cnt_s > tgt_s);
    stall_s    = issue_valid_i && (raw_s || waw_s);
    acc_s      = issue_valid_i && !stall_s;
    wr_acc_s   = acc_s && issue_wr_i &&
                 !((ZERO_REG != 0) && (issue_rd_i == {REG_ADDR_W{1'b0}}));
  end

  assign stall_o     = stall_s;
  assign issue_acc_o = acc_s;
  assign fwd_rs_o = (issue_use_rs_i && (rs_cnt_s != {CNT_W{1'b0}}) && (rs_cnt_s <= WB_C)) ? rs_cnt_s : FWD_RF;
  assign fwd_rt_o = (issue_use_rt_i && (rt_cnt_s != {CNT_W{1'b0}}) && (rt_cnt_s <= WB_C)) ? rt_cnt_s : FWD_RF;

  // Last-accepted-write record used to undo a flushed issue.
  always_comb begin
    lw_valid_d    = wr_acc_s;
    lw_reg_d      = wr_acc_s ? issue_rd_i : lw_reg_q;
    lw_prev_d     = wr_acc_s ? rd_cnt_s : lw_prev_q;
    restore_s     = flush_i && lw_valid_q;
    restore_val_s = (lw_prev_q != {CNT_W{1'b0}}) ? (lw_prev_q - ONE_C) : {CNT_W{1'b0}};
  end

  // Last-write registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lw_valid_q <= 1'b0;
      lw_reg_q   <= {REG_ADDR_W{1'b0}};
      lw_prev_q  <= {CNT_W{1'b0}};
    end else begin
      lw_valid_q <= lw_valid_d;
      lw_reg_q   <= lw_reg_d;
      lw_prev_q  <= lw_prev_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    sb_cell #(.CNT_W(CNT_W)) u_cell (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_i        (wr_acc_s && (issue_rd_i == REG_ADDR_W'(g))),
      .load_val_i    (load_val_s),
      .restore_i     (restore_s && (lw_reg_q == REG_ADDR_W'(g))),
      .restore_val_i (restore_val_s),
      .cnt_o         (cnt_s[g])
    );
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stat_raw_q, stat_raw_d, stat_waw_q, stat_waw_d;

  // Stall-cycle counters; a cycle with both causes bumps both.
  always_comb begin
    stat_raw_d = (issue_valid_i && raw_s) ? (stat_raw_q + 32'd1) : stat_raw_q;
    stat_waw_d = (issue_valid_i && waw_s) ? (stat_waw_q + 32'd1) : stat_waw_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_raw_q <= 32'd0;
      stat_waw_q <= 32'd0;
    end else begin
      stat_raw_q <= stat_raw_d;
      stat_waw_q <= stat_waw_d;
    end
  end

  assign stat_raw_o = stat_raw_q;
  assign stat_waw_o = stat_waw_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard (default parameters, WB_DIST=2);
// covers the stats outputs when SCOREBOARD_STATS_EN is defined.
module tb_pipe_hazard_scoreboard;
  import pipe_hz_pkg::*;

  localparam int CW = cnt_width(7, 2);

  logic          clk, rst_n;
  logic          valid, use_rs, use_rt, wr, flush;
  logic [4:0]    rs, rt, rd;
  logic [CW-1:0] lat;
  logic          stall, acc;
  logic [CW-1:0] fwd_rs, fwd_rt;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]   stat_raw, stat_waw;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid_i  (valid),
    .issue_rs_i     (rs),
    .issue_rt_i     (rt),
    .issue_use_rs_i (use_rs),
    .issue_use_rt_i (use_rt),
    .issue_wr_i     (wr),
    .issue_rd_i     (rd),
    .issue_lat_i    (lat),
    .flush_i        (flush),
    .stall_o        (stall),
    .issue_acc_o    (acc),
    .fwd_rs_o       (fwd_rs),
    .fwd_rt_o       (fwd_rt)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stat_raw_o     (stat_raw),
    .stat_waw_o     (stat_waw)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one decode slot at the falling edge and settle before sampling.
  task automatic issue(input logic v, input logic [4:0] s, input logic us,
                       input logic [4:0] t, input logic ut, input logic w,
                       input logic [4:0] d, input logic [CW-1:0] l);
    @(negedge clk);
    valid = v; rs = s; use_rs = us; rt = t; use_rt = ut;
    wr = w; rd = d; lat = l; flush = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    issue(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 5'd8, 4'd2);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", stall); end
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL reset_acc: got %0d want 1", acc); end
    n_cmp++; if (fwd_rs !== 4'd0) begin n_bad++; $display("FAIL reset_fwd_rs: got %0d want 0", fwd_rs); end
    n_cmp++; if (fwd_rt !== 4'd0) begin n_bad++; $display("FAIL reset_fwd_rt: got %0d want 0", fwd_rt); end
    idle(1);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_load_use;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 4'd2);
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL lu_accept: got %0d want 1", acc); end
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %0d want 1", stall); end
    n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL lu_acc_held: got %0d want 0", acc); end
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %0d want 0", stall); end
    n_cmp++; if (fwd_rs !== 4'd2) begin n_bad++; $display("FAIL lu_fwd2: got %0d want 2", fwd_rs); end
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (fwd_rs !== 4'd1) begin n_bad++; $display("FAIL lu_fwd1: got %0d want 1", fwd_rs); end
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (fwd_rs !== 4'd0) begin n_bad++; $display("FAIL lu_fwd0: got %0d want 0", fwd_rs); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 4'd1);
    issue(1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %0d want 0", stall); end
    n_cmp++; if (fwd_rt !== 4'd2) begin n_bad++; $display("FAIL b2b_fwd_rt: got %0d want 2", fwd_rt); end
    n_cmp++; if (fwd_rs !== 4'd0) begin n_bad++; $display("FAIL b2b_unused_rs: got %0d want 0", fwd_rs); end
    idle(3);
  endtask

  task automatic test_waw;
    int  stalls;
    logic done;
    stalls = 0;
    done = 1'b0;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 4'd7);
    for (int i = 0; i < 20 && !done; i++) begin
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 4'd1);
      if (acc === 1'b1) done = 1'b1;
      else stalls++;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL waw_timeout: got %0d want 1", done); end
    n_cmp++; if (stalls !== 5) begin n_bad++; $display("FAIL waw_stall_cycles: got %0d want 5", stalls); end
    issue(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL waw_after_stall: got %0d want 0", stall); end
    n_cmp++; if (fwd_rs !== 4'd2) begin n_bad++; $display("FAIL waw_after_fwd: got %0d want 2", fwd_rs); end
    idle(3);
  endtask

  task automatic test_flush;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 4'd2);
    issue(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_pre_stall: got %0d want 1", stall); end
    issue(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0d want 0", stall); end
    n_cmp++; if (fwd_rs !== 4'd0) begin n_bad++; $display("FAIL flush_fwd: got %0d want 0", fwd_rs); end
    idle(2);
  endtask

  task automatic test_zero_reg;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 4'd5);
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL zero_acc: got %0d want 1", acc); end
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %0d want 0", stall); end
    n_cmp++; if (fwd_rs !== 4'd0) begin n_bad++; $display("FAIL zero_fwd_rs: got %0d want 0", fwd_rs); end
    idle(2);
  endtask

  task automatic test_lat_clamp;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 4'd0);
    issue(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL clamp_lo_stall: got %0d want 0", stall); end
    n_cmp++; if (fwd_rs !== 4'd2) begin n_bad++; $display("FAIL clamp_lo_fwd: got %0d want 2", fwd_rs); end
    idle(2);
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 4'd15);
    // Clamped to 7: next cycle count is 8, so a lat=5 write to r13 (7) is a WAW stall, lat=6 (8) is not.
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 4'd5);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL clamp_hi_waw: got %0d want 1", stall); end
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 4'd5);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL clamp_hi_release: got %0d want 0", stall); end
    idle(10);
  endtask

  task automatic test_async_reset;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 4'd2);
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ar_pre_stall: got %0d want 1", stall); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ar_stall: got %0d want 0", stall); end
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL ar_acc: got %0d want 1", acc); end
    n_cmp++; if (fwd_rs !== 4'd0) begin n_bad++; $display("FAIL ar_fwd: got %0d want 0", fwd_rs); end
`ifdef SCOREBOARD_STATS_EN
    n_cmp++; if (stat_raw !== 32'd0) begin n_bad++; $display("FAIL ar_stat_raw: got %0d want 0", stat_raw); end
    n_cmp++; if (stat_waw !== 32'd0) begin n_bad++; $display("FAIL ar_stat_waw: got %0d want 0", stat_waw); end
`endif
    idle(1);
    rst_n = 1'b1;
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ar_post_stall: got %0d want 0", stall); end
    n_cmp++; if (fwd_rs !== 4'd0) begin n_bad++; $display("FAIL ar_post_fwd: got %0d want 0", fwd_rs); end
    idle(2);
  endtask

`ifdef SCOREBOARD_STATS_EN
  task automatic test_stats;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd14, 4'd7);
    issue(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 1'b1, 5'd14, 4'd1);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stats_stall: got %0d want 1", stall); end
    idle(1);
    n_cmp++; if (stat_raw !== 32'd1) begin n_bad++; $display("FAIL stats_raw: got %0d want 1", stat_raw); end
    n_cmp++; if (stat_waw !== 32'd1) begin n_bad++; $display("FAIL stats_waw: got %0d want 1", stat_waw); end
    idle(10);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    valid = 1'b0; use_rs = 1'b0; use_rt = 1'b0; wr = 1'b0; flush = 1'b0;
    rs = 5'd0; rt = 5'd0; rd = 5'd0; lat = 4'd1;
    test_reset;
    test_load_use;
    test_back_to_back;
    test_waw;
    test_flush;
    test_zero_reg;
    test_lat_clamp;
    test_async_reset;
`ifdef SCOREBOARD_STATS_EN
    test_stats;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
